// File: rtl/secret_gen.sv
// secret_gen: draws a four-digit secret with pairwise-distinct BCD digits.
// A free-running 16-bit Galois LFSR supplies one candidate nibble per DRAW
// cycle. A candidate is accepted if it is a decimal digit not already drawn.
// All outputs are registered.
module secret_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [15:0] answer
);

    localparam int unsigned LfsrW    = 16;
    localparam int unsigned DigitW   = 4;
    localparam int unsigned NumSlots = 4;
    localparam int unsigned IdxW     = 2;
    localparam int unsigned SlotsW   = DigitW * NumSlots;

    localparam logic [LfsrW-1:0]  LfsrTaps    = 16'hB400;
    localparam logic [LfsrW-1:0]  LfsrDefault = 16'hACE1;
    localparam logic [DigitW-1:0] MaxDigit    = 4'd9;
    localparam logic [IdxW-1:0]   LastIdx     = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LfsrW-1:0]    lfsr_q, lfsr_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [SlotsW-1:0]   slots_q, slots_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic [SlotsW-1:0]   answer_q, answer_d;

    logic [DigitW-1:0]   cand_c;
    logic                dup_c;
    logic                accept_c;

    // LFSR advances every cycle; a seed load takes priority, and a zero seed
    // is replaced so the register can never lock up at all-zeros.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LfsrW-1:1]} ^ (lfsr_q[0] ? LfsrTaps : '0);
        if (seed_load) begin
            lfsr_d = (seed == '0) ? LfsrDefault : seed;
        end
    end

    // Candidate is accepted when it is a decimal digit not yet in a filled slot.
    always_comb begin
        cand_c = lfsr_q[DigitW-1:0];
        dup_c  = 1'b0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            if ((IdxW'(i) < idx_q) && (slots_q[{IdxW'(i), 2'b00} +: DigitW] == cand_c)) begin
                dup_c = 1'b1;
            end
        end
        accept_c = (cand_c <= MaxDigit) && !dup_c;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        slots_d  = slots_q;
        valid_d  = valid_q;
        answer_d = answer_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAW;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end
            end
            DRAW: begin
                if (accept_c) begin
                    slots_d[{idx_q, 2'b00} +: DigitW] = cand_c;
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        // Commit all four digits on one edge.
                        answer_d = {cand_c, slots_q[SlotsW-DigitW-1:0]};
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= LfsrDefault;
            idx_q    <= '0;
            slots_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            answer_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            idx_q    <= idx_d;
            slots_q  <= slots_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            answer_q <= answer_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign valid  = valid_q;
    assign answer = answer_q;

endmodule
